// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read-side (and future write-side) arbiters:
// FSM encoding, AXI burst/response constants and the grant-index width helper.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // A one-requester arbiter still needs a 1-bit grant index.
    function automatic int grant_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Combinational round-robin picker: the first requester after last_grant_i,
// wrapping modulo NUM_REQ, wins. Shared by the read and write arbiters.
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      last_grant_i,
    output logic [GW-1:0]      grant_o,
    output logic               any_req_o
);

    logic found;

    // Offsets run 1..NUM_REQ so the last winner is examined last.
    always_comb begin
        grant_o = last_grant_i;
        found   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && req_i[(int'(last_grant_i) + off) % NUM_REQ]) begin
                grant_o = GW'((int'(last_grant_i) + off) % NUM_REQ);
                found   = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/axi_read_arbiter.sv
// N:1 round-robin arbiter sharing the RAM read port between AXI4 read
// requesters, one complete burst at a time.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 8
) (
    input  logic                                   axi_clk,
    input  logic                                   axi_resetn,

    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  s_ar_addr,
    input  logic [NUM_MASTERS*2-1:0]               s_ar_burst,
    input  logic [NUM_MASTERS*3-1:0]               s_ar_size,
    input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]    s_ar_id,
    input  logic [NUM_MASTERS*8-1:0]               s_ar_len,
    input  logic [NUM_MASTERS-1:0]                 s_ar_valid,
    output logic [NUM_MASTERS-1:0]                 s_ar_ready,
    output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]  s_r_data,
    output logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]    s_r_id,
    output logic [NUM_MASTERS*2-1:0]               s_r_resp,
    output logic [NUM_MASTERS-1:0]                 s_r_last,
    output logic [NUM_MASTERS-1:0]                 s_r_valid,
    input  logic [NUM_MASTERS-1:0]                 s_r_ready,

    output logic [AXI_ADDR_WIDTH-1:0]              m_ar_addr,
    output logic [1:0]                             m_ar_burst,
    output logic [2:0]                             m_ar_size,
    output logic [AXI_ID_WIDTH-1:0]                m_ar_id,
    output logic [7:0]                             m_ar_len,
    output logic                                   m_ar_valid,
    input  logic                                   m_ar_ready,
    input  logic [AXI_DATA_WIDTH-1:0]              m_r_data,
    input  logic [AXI_ID_WIDTH-1:0]                m_r_id,
    input  logic [1:0]                             m_r_resp,
    input  logic                                   m_r_last,
    input  logic                                   m_r_valid,
    output logic                                   m_r_ready
);

    localparam int GW = grant_width(NUM_MASTERS);
    localparam logic [GW-1:0] LAST_GRANT_INIT = GW'(NUM_MASTERS - 1);

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [GW-1:0]     rr_grant;
    logic              rr_any;
    logic              ar_fire;
    logic [NUM_MASTERS-1:0] sel;

    logic [AXI_ADDR_WIDTH-1:0] ar_addr_arr  [NUM_MASTERS];
    logic [1:0]                ar_burst_arr [NUM_MASTERS];
    logic [2:0]                ar_size_arr  [NUM_MASTERS];
    logic [AXI_ID_WIDTH-1:0]   ar_id_arr    [NUM_MASTERS];
    logic [7:0]                ar_len_arr   [NUM_MASTERS];

    rr_arbiter #(
        .NUM_REQ (NUM_MASTERS),
        .GW      (GW)
    ) u_rr (
        .req_i        (s_ar_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .any_req_o    (rr_any)
    );

    // Unpack requester lanes; R payload is broadcast, only valid/ready are steered.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
            assign ar_addr_arr[gi]  = s_ar_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            assign ar_burst_arr[gi] = s_ar_burst[gi*2 +: 2];
            assign ar_size_arr[gi]  = s_ar_size[gi*3 +: 3];
            assign ar_id_arr[gi]    = s_ar_id[gi*AXI_ID_WIDTH +: AXI_ID_WIDTH];
            assign ar_len_arr[gi]   = s_ar_len[gi*8 +: 8];

            assign sel[gi]        = (grant_q == GW'(gi));
            assign s_ar_ready[gi] = (state_q == ST_ADDR) && sel[gi] && m_ar_ready;
            assign s_r_valid[gi]  = (state_q == ST_DATA) && sel[gi] && m_r_valid;

            assign s_r_data[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_r_data;
            assign s_r_id[gi*AXI_ID_WIDTH +: AXI_ID_WIDTH]       = m_r_id;
            assign s_r_resp[gi*2 +: 2]                           = m_r_resp;
            assign s_r_last[gi]                                  = m_r_last;
        end
    endgenerate

    // One-hot AND-OR mux keeps the AR path free of out-of-range indexing.
    always_comb begin
        m_ar_addr  = '0;
        m_ar_burst = '0;
        m_ar_size  = '0;
        m_ar_id    = '0;
        m_ar_len   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel[i]) begin
                m_ar_addr  = ar_addr_arr[i];
                m_ar_burst = ar_burst_arr[i];
                m_ar_size  = ar_size_arr[i];
                m_ar_id    = ar_id_arr[i];
                m_ar_len   = ar_len_arr[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_ar_valid   = 1'b0;
        m_r_ready    = 1'b1;
        ar_fire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_d      = rr_grant;
                    last_grant_d = rr_grant;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_ar_valid = |(s_ar_valid & sel);
                ar_fire    = m_ar_valid && m_ar_ready;
                if (ar_fire) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // The RAM stalls its read pipeline on r_ready, so ready is
                // only ever lowered by the owning requester.
                m_r_ready = |(s_r_ready & sel);
                if (m_r_valid && m_r_ready && m_r_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_INIT;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with a small behavioural RAM read port
// behind it and a per-requester R-beat monitor.
module tb_axi_read_arbiter;
    import axi_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int IW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] ar_addr  [N];
    logic [1:0]    ar_burst [N];
    logic [2:0]    ar_size  [N];
    logic [IW-1:0] ar_id    [N];
    logic [7:0]    ar_len   [N];
    logic [N-1:0]  ar_valid;
    logic [N-1:0]  r_ready;

    logic [N*AW-1:0] s_ar_addr;
    logic [N*2-1:0]  s_ar_burst;
    logic [N*3-1:0]  s_ar_size;
    logic [N*IW-1:0] s_ar_id;
    logic [N*8-1:0]  s_ar_len;
    logic [N-1:0]    s_ar_ready;
    logic [N*DW-1:0] s_r_data;
    logic [N*IW-1:0] s_r_id;
    logic [N*2-1:0]  s_r_resp;
    logic [N-1:0]    s_r_last;
    logic [N-1:0]    s_r_valid;

    logic [AW-1:0] m_ar_addr;
    logic [1:0]    m_ar_burst;
    logic [2:0]    m_ar_size;
    logic [IW-1:0] m_ar_id;
    logic [7:0]    m_ar_len;
    logic          m_ar_valid;
    logic          m_ar_ready;
    logic [DW-1:0] m_r_data;
    logic [IW-1:0] m_r_id;
    logic [1:0]    m_r_resp;
    logic          m_r_last;
    logic          m_r_valid;
    logic          m_r_ready;

    assign s_ar_addr  = {ar_addr[1],  ar_addr[0]};
    assign s_ar_burst = {ar_burst[1], ar_burst[0]};
    assign s_ar_size  = {ar_size[1],  ar_size[0]};
    assign s_ar_id    = {ar_id[1],    ar_id[0]};
    assign s_ar_len   = {ar_len[1],   ar_len[0]};

    axi_read_arbiter #(
        .NUM_MASTERS    (N),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW)
    ) dut (
        .axi_clk    (clk),
        .axi_resetn (rstn),
        .s_ar_addr  (s_ar_addr),
        .s_ar_burst (s_ar_burst),
        .s_ar_size  (s_ar_size),
        .s_ar_id    (s_ar_id),
        .s_ar_len   (s_ar_len),
        .s_ar_valid (ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_r_data   (s_r_data),
        .s_r_id     (s_r_id),
        .s_r_resp   (s_r_resp),
        .s_r_last   (s_r_last),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (r_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_burst (m_ar_burst),
        .m_ar_size  (m_ar_size),
        .m_ar_id    (m_ar_id),
        .m_ar_len   (m_ar_len),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_r_data   (m_r_data),
        .m_r_id     (m_r_id),
        .m_r_resp   (m_r_resp),
        .m_r_last   (m_r_last),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready)
    );

    // ---------------- behavioural RAM read port ----------------
    logic [DW-1:0] ram [0:511];
    logic          ram_busy;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_burst;
    logic [7:0]    ram_left;

    assign m_ar_ready = rstn && !ram_busy;
    assign m_r_resp   = RESP_OKAY;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_busy  <= 1'b0;
            ram_addr  <= '0;
            ram_burst <= '0;
            ram_left  <= '0;
            m_r_valid <= 1'b0;
            m_r_last  <= 1'b0;
            m_r_data  <= '0;
            m_r_id    <= '0;
        end else if (!ram_busy) begin
            if (m_ar_valid) begin
                ram_busy  <= 1'b1;
                ram_addr  <= m_ar_addr;
                ram_burst <= m_ar_burst;
                ram_left  <= m_ar_len;
                m_r_id    <= m_ar_id;
                m_r_valid <= 1'b1;
                m_r_data  <= ram[m_ar_addr[11:3]];
                m_r_last  <= (m_ar_len == 8'd0);
            end
        end else if (m_r_valid && m_r_ready) begin
            if (m_r_last) begin
                ram_busy  <= 1'b0;
                m_r_valid <= 1'b0;
                m_r_last  <= 1'b0;
            end else begin
                ram_addr <= (ram_burst == BURST_FIXED) ? ram_addr : ram_addr + 12'd8;
                m_r_data <= ram[(ram_burst == BURST_FIXED) ? ram_addr[11:3] : ram_addr[11:3] + 9'd1];
                ram_left <= ram_left - 8'd1;
                m_r_last <= (ram_left == 8'd1);
            end
        end
    end

    // ---------------- monitor ----------------
    beat_t         q0[$];
    beat_t         q1[$];
    logic [IW-1:0] ar_order[$];
    int            multi_grant = 0;
    int            mirror_err  = 0;
    int            mirror_seen = 0;

    always @(negedge clk) begin
        if (s_r_valid[0] && r_ready[0]) q0.push_back({s_r_data[63:0], s_r_id[7:0], s_r_last[0]});
        if (s_r_valid[1] && r_ready[1]) q1.push_back({s_r_data[127:64], s_r_id[15:8], s_r_last[1]});
        if (m_ar_valid && m_ar_ready) ar_order.push_back(m_ar_id);
        if ($countones(s_r_valid) > 1 || $countones(s_ar_ready) > 1) multi_grant++;
        if (s_r_valid[1]) begin
            mirror_seen++;
            if (m_r_ready != r_ready[1]) mirror_err++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [63:0] ram_init(input int w);
        return 64'h0001_0000_0000_0000 | 64'(w);
    endfunction

    task automatic do_reset();
        rstn     = 1'b0;
        ar_valid = '0;
        r_ready  = '1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        q0.delete();
        q1.delete();
        ar_order.delete();
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the AR handshake.
    task automatic issue_ar(input int m, input logic [11:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [7:0] id);
        bit done = 1'b0;
        ar_addr[m]  = addr;
        ar_len[m]   = len;
        ar_burst[m] = burst;
        ar_size[m]  = 3'd3;
        ar_id[m]    = id;
        ar_valid[m] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (s_ar_ready[m]) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ar_valid[m] = 1'b0;
        check_eq($sformatf("ar_handshake_m%0d_id%02h", m, id), 64'(done), 64'd1);
    endtask

    task automatic wait_beats(input int m, input int n, input string tag);
        for (int c = 0; c < 400; c++) begin
            if (((m == 0) ? q0.size() : q1.size()) >= n) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check_eq(tag, 64'((m == 0) ? q0.size() : q1.size()), 64'(n));
    endtask

    task automatic check_beats(input int m, input int n, input int base_w, input bit fixed,
                               input logic [63:0] fixed_data, input logic [7:0] id, input string tag);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            if (k < ((m == 0) ? q0.size() : q1.size())) begin
                b = (m == 0) ? q0[k] : q1[k];
                check_eq($sformatf("%s_data%0d", tag, k), b.data,
                         fixed ? fixed_data : ram_init(base_w + k));
                check_eq($sformatf("%s_id%0d", tag, k), 64'(b.id), 64'(id));
                check_eq($sformatf("%s_last%0d", tag, k), 64'(b.last), 64'(k == n - 1));
            end
        end
    endtask

    initial begin
        int seen;
        logic [3:0] pat;

        for (int i = 0; i < 512; i++) ram[i] = ram_init(i);
        for (int i = 0; i < N; i++) begin
            ar_addr[i] = '0; ar_burst[i] = '0; ar_size[i] = '0; ar_id[i] = '0; ar_len[i] = '0;
        end
        ar_valid = '0;
        r_ready  = '1;
        #1;
        do_reset();

        // Reset state
        @(negedge clk);
        check_eq("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
        check_eq("rst_s_r_valid",  64'(s_r_valid),  64'd0);
        check_eq("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check_eq("rst_m_r_ready",  64'(m_r_ready),  64'd1);

        // 1: single requester, latency and 4-beat INCR burst
        @(posedge clk); #1;
        ar_addr[0] = 12'h040; ar_len[0] = 8'd3; ar_burst[0] = BURST_INCR;
        ar_size[0] = 3'd3;    ar_id[0] = 8'h11; ar_valid[0] = 1'b1;
        @(negedge clk);
        check_eq("t1_m_ar_valid_cycleN",  64'(m_ar_valid), 64'd0);
        @(negedge clk);
        check_eq("t1_m_ar_valid_cycleN1", 64'(m_ar_valid), 64'd1);
        check_eq("t1_m_ar_addr", 64'(m_ar_addr), 64'h040);
        check_eq("t1_m_ar_len",  64'(m_ar_len),  64'd3);
        check_eq("t1_m_ar_id",   64'(m_ar_id),   64'h11);
        check_eq("t1_s_ar_ready0", 64'(s_ar_ready), 64'b01);
        @(posedge clk); #1;
        ar_valid[0] = 1'b0;
        wait_beats(0, 4, "t1_beats_m0");
        check_beats(0, 4, 8, 1'b0, 64'd0, 8'h11, "t1");
        check_eq("t1_beats_m1", 64'(q1.size()), 64'd0);

        // 2: simultaneous requests after reset, then again
        do_reset();
        @(posedge clk); #1;
        fork
            issue_ar(0, 12'h000, 8'd1, BURST_INCR, 8'hA0);
            issue_ar(1, 12'h080, 8'd1, BURST_INCR, 8'hB1);
        join
        wait_beats(0, 2, "t2_beats_m0");
        wait_beats(1, 2, "t2_beats_m1");
        check_eq("t2_order0", 64'(ar_order.size() > 0 ? ar_order[0] : 8'hFF), 64'hA0);
        check_eq("t2_order1", 64'(ar_order.size() > 1 ? ar_order[1] : 8'hFF), 64'hB1);
        check_beats(1, 2, 16, 1'b0, 64'd0, 8'hB1, "t2_m1");
        q0.delete(); q1.delete(); ar_order.delete();
        @(posedge clk); #1;
        fork
            issue_ar(0, 12'h000, 8'd1, BURST_INCR, 8'hA2);
            issue_ar(1, 12'h080, 8'd1, BURST_INCR, 8'hB3);
        join
        wait_beats(1, 2, "t2b_beats_m1");
        check_eq("t2b_order0", 64'(ar_order.size() > 0 ? ar_order[0] : 8'hFF), 64'hA2);
        check_eq("t2b_order1", 64'(ar_order.size() > 1 ? ar_order[1] : 8'hFF), 64'hB3);

        // 3: back-pressure from M1 with ready pattern 1,0,0,1
        q0.delete(); q1.delete(); ar_order.delete();
        pat = 4'b1001;
        @(posedge clk); #1;
        fork
            issue_ar(1, 12'h200, 8'd7, BURST_INCR, 8'h33);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk); #1;
                    r_ready[1] = pat[c % 4];
                    if (q1.size() >= 8) break;
                end
                r_ready[1] = 1'b1;
            end
        join
        wait_beats(1, 8, "t3_beats_m1");
        check_beats(1, 8, 64, 1'b0, 64'd0, 8'h33, "t3");
        check_eq("t3_mirror_err", 64'(mirror_err), 64'd0);
        check_eq("t3_mirror_seen", 64'(mirror_seen > 8), 64'd1);

        // 4: M0 continuous, M1 once -> M1 served right after M0's first burst
        q0.delete(); q1.delete(); ar_order.delete();
        @(posedge clk); #1;
        fork
            begin
                issue_ar(0, 12'h000, 8'd1, BURST_INCR, 8'hC0);
                issue_ar(0, 12'h000, 8'd1, BURST_INCR, 8'hC2);
                issue_ar(0, 12'h000, 8'd1, BURST_INCR, 8'hC4);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                issue_ar(1, 12'h080, 8'd1, BURST_INCR, 8'hD1);
            end
        join
        wait_beats(0, 6, "t4_beats_m0");
        check_eq("t4_order0", 64'(ar_order.size() > 0 ? ar_order[0] : 8'hFF), 64'hC0);
        check_eq("t4_order1", 64'(ar_order.size() > 1 ? ar_order[1] : 8'hFF), 64'hD1);
        check_eq("t4_order2", 64'(ar_order.size() > 2 ? ar_order[2] : 8'hFF), 64'hC2);
        check_eq("t4_order3", 64'(ar_order.size() > 3 ? ar_order[3] : 8'hFF), 64'hC4);

        // 5: reset during beat 2 of a len=5 burst
        q0.delete(); q1.delete(); ar_order.delete();
        @(posedge clk); #1;
        issue_ar(0, 12'h300, 8'd5, BURST_INCR, 8'h55);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (s_r_valid[0]) seen++;
            if (seen == 2) break;
        end
        check_eq("t5_reached_beat2", 64'(seen), 64'd2);
        rstn = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
        check_eq("t5_rst_s_r_valid",  64'(s_r_valid),  64'd0);
        check_eq("t5_rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check_eq("t5_rst_m_r_ready",  64'(m_r_ready),  64'd1);
        @(negedge clk);
        rstn = 1'b1;
        q0.delete(); q1.delete(); ar_order.delete();
        @(posedge clk); #1;
        issue_ar(1, 12'h010, 8'd1, BURST_INCR, 8'h5A);
        wait_beats(1, 2, "t5_fresh_beats_m1");
        check_beats(1, 2, 2, 1'b0, 64'd0, 8'h5A, "t5_fresh");

        // 6: FIXED burst of a word M0 wrote through the write path
        ram[9'h020] = 64'h0000_0000_DEAD_BEEF;
        q0.delete(); q1.delete(); ar_order.delete();
        @(posedge clk); #1;
        issue_ar(1, 12'h100, 8'd2, BURST_FIXED, 8'h66);
        wait_beats(1, 3, "t6_beats_m1");
        check_beats(1, 3, 0, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h66, "t6");
        check_eq("t6_beats_m0", 64'(q0.size()), 64'd0);

        check_eq("multi_grant_events", 64'(multi_grant), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- N:1 round-robin arbiter that shares the single read port of the simple dual-port AXI RAM between NUM_MASTERS AXI4 read requesters.
- Grants one complete burst at a time. The AR channel of the granted requester goes to the RAM. R beats route back to that requester until RLAST.
- Sits between requester read ports (DMA, CPU, debug) and the RAM read port. The write path is untouched.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8)
- AXI_ADDR_WIDTH, 12, byte address width
- AXI_DATA_WIDTH, 64, data width in bits
- AXI_ID_WIDTH, 8, ID width, passed through unchanged

Ports:
Requester ports are packed; requester i occupies bits [i*W +: W].
- axi_clk  in  1  clock
- axi_resetn  in  1  asynchronous active-low reset
- s_ar_addr  in  NUM_MASTERS*AXI_ADDR_WIDTH  requester AR address
- s_ar_burst  in  NUM_MASTERS*2  requester burst type
- s_ar_size  in  NUM_MASTERS*3  requester size
- s_ar_id  in  NUM_MASTERS*AXI_ID_WIDTH  requester ID
- s_ar_len  in  NUM_MASTERS*8  requester burst length-1
- s_ar_valid  in  NUM_MASTERS  requester AR valid
- s_ar_ready  out  NUM_MASTERS  requester AR ready
- s_r_data  out  NUM_MASTERS*AXI_DATA_WIDTH  read data (broadcast)
- s_r_id  out  NUM_MASTERS*AXI_ID_WIDTH  read ID (broadcast)
- s_r_resp  out  NUM_MASTERS*2  read response (broadcast)
- s_r_last  out  NUM_MASTERS  read last (broadcast)
- s_r_valid  out  NUM_MASTERS  read valid, granted requester only
- s_r_ready  in  NUM_MASTERS  requester R ready
- m_ar_addr/m_ar_burst/m_ar_size/m_ar_id/m_ar_len  out  single-port widths  AR channel to RAM
- m_ar_valid  out  1  AR valid to RAM
- m_ar_ready  in  1  AR ready from RAM
- m_r_data/m_r_id/m_r_resp/m_r_last  in  single-port widths  R channel from RAM
- m_r_valid  in  1  R valid from RAM
- m_r_ready  out  1  R ready to RAM

Behaviour:
- Reset and clocking: one clock, axi_clk. Reset axi_resetn is asynchronous, active-low.
- Reset values:
  - state=IDLE
  - grant=0
  - last_grant=NUM_MASTERS-1, so requester 0 wins first
  - s_ar_ready=0, s_r_valid=0, m_ar_valid=0
  - m_r_ready=1
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_ar_valid: grant <= first requesting index searching last_grant+1, +2, ... modulo NUM_MASTERS.
  - last_grant <= that index; go to ADDR.
  - Latency: valid seen in cycle N, m_ar_valid high in cycle N+1.
- ADDR:
  - m_ar_* = s_ar_*[grant] (combinational mux); m_ar_valid = s_ar_valid[grant].
  - s_ar_ready[grant] = m_ar_ready; all other s_ar_ready = 0.
  - On the m_ar_valid && m_ar_ready handshake, go to DATA.
- DATA:
  - s_r_valid[grant] = m_r_valid; m_r_ready = s_r_ready[grant].
  - On m_r_valid && m_r_ready && m_r_last, go to IDLE. A new arbitration may grant in the next cycle.
- m_r_ready is held at 1 in IDLE and ADDR. This is mandatory because the RAM gates ar_ready and its read pipeline on r_ready. Only one burst is ever outstanding, so no data is lost.
- R data/id/resp/last are broadcast to all requesters; only s_r_valid is steered to the granted requester.
- Non-granted requesters see s_ar_ready=0 and s_r_valid=0 at all times.
- Simultaneous requests: strict round-robin. A requester that was just served has lowest priority next.
- A requester dropping s_ar_valid in ADDR violates AXI. The arbiter stays in ADDR until a handshake occurs.
- m_r_valid outside DATA is dropped. It cannot occur with the RAM.
- Reset mid-burst: FSM returns to IDLE immediately and all valids deassert. The RAM shares the reset, so no orphan beats remain.
- No ID remapping; IDs pass through unchanged both ways.

Decomposition:
- Shared package axi_arb_pkg:
  - state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2)
  - AXI burst constants FIXED/INCR/WRAP
  - RESP_OKAY
  - function for grant width = max(1, clog2(NUM_MASTERS))
- Sub-module rr_arbiter: takes a request vector and last_grant, outputs the next grant index and any_req. It is combinational and reused by a future write-side arbiter.

Test Plan:
1. Single requester: M0 AR addr=0x040, len=3, INCR, id=0x11 -> m_ar_valid one cycle after s_ar_valid. Exactly 4 beats reach s_r_valid[0] with id 0x11, s_r_last on the 4th. s_r_valid[1] stays 0.
2. Simultaneous M0/M1 AR after reset -> M0 served first, then M1. Then M0 and M1 re-request together -> M0 is granted again, because M1 was the last served.
3. Back-pressure: M1 burst len=7 with s_r_ready[1] toggling 1,0,0,1 -> m_r_ready mirrors it, 8 beats delivered in order, no duplicate or lost beat.
4. M0 requests continuously while M1 requests once -> M1 is granted immediately after M0's RLAST handshake (no starvation).
5. Assert axi_resetn low during beat 2 of a len=5 burst -> next cycle: state IDLE, all s_ar_ready/s_r_valid 0, m_r_ready=1. A fresh request after reset completes normally.
6. FIXED burst len=2 addr=0x100 by M1 after M0 wrote 0xDEADBEEF there -> 3 beats of 0xDEADBEEF to M1 only.
